// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared helpers for the pipelined carry-skip adder
package csa_pkg;

    // Number of skip blocks, which is also the pipeline depth.
    function automatic int csa_nblk(input int width, input int blk);
        return (blk > 0) ? (width / blk) : 1;
    endfunction

    // True when the operand width splits evenly into skip blocks.
    function automatic bit csa_fits(input int width, input int blk);
        return (blk > 0) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// rtl/csa_skip_block.sv - combinational BLK-bit ripple adder with carry-skip mux
//   a, b : block operands (b already inverted for subtraction)
//   ci   : carry into the block
//   s    : block sum
//   co   : block carry out (skip path when every bit propagates)
//   p    : group propagate
module csa_skip_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           p
);

    logic [BLK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
        p  = &(a ^ b);
        // When the whole block propagates, the incoming carry bypasses the ripple chain.
        co = p ? ci : c[BLK];
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-skip adder/subtractor, one block per stage
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (s, cout, ovf, skip_mask)
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     s,
    output logic                 cout,
    output logic                 ovf,
    output logic [WIDTH/BLK-1:0] skip_mask
);

    localparam int NBLK = csa_nblk(WIDTH, BLK);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [NBLK-1:0]  mask_t;

    if (!csa_fits(WIDTH, BLK)) begin : g_width_check
        $fatal(1, "csa_pipe_adder: WIDTH must be a multiple of BLK");
    end

    // Stage registers: bank k holds the state after block k has been resolved.
    logic [NBLK-1:0] v_q;
    logic [NBLK-1:0] c_q;
    word_t           sum_q  [NBLK];
    word_t           ar_q   [NBLK];
    word_t           br_q   [NBLK];
    mask_t           mask_q [NBLK];
    logic            ovf_q;

    // Per-stage sources: stage 0 reads the ports, later stages read the previous bank.
    word_t           src_a    [NBLK];
    word_t           src_b    [NBLK];
    word_t           src_sum  [NBLK];
    mask_t           src_mask [NBLK];
    logic [NBLK-1:0] src_v;
    logic [NBLK-1:0] src_c;

    logic [BLK-1:0]  blk_s [NBLK];
    logic [NBLK-1:0] blk_co;
    logic [NBLK-1:0] blk_p;

    logic            en;
    word_t           b_eff;
    logic            c0;
    logic            ovf_nxt;

    // A full output with no taker freezes the whole pipeline, bubbles included.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src_a[k]    = a;
            assign src_b[k]    = b_eff;
            assign src_c[k]    = c0;
            assign src_sum[k]  = '0;
            assign src_mask[k] = '0;
            assign src_v[k]    = in_valid;
        end else begin : g_next
            assign src_a[k]    = ar_q[k-1];
            assign src_b[k]    = br_q[k-1];
            assign src_c[k]    = c_q[k-1];
            assign src_sum[k]  = sum_q[k-1];
            assign src_mask[k] = mask_q[k-1];
            assign src_v[k]    = v_q[k-1];
        end

        // Unconsumed operand bits are shifted down, so the current block is always at the bottom.
        csa_skip_block #(.BLK(BLK)) u_blk (
            .a  (src_a[k][BLK-1:0]),
            .b  (src_b[k][BLK-1:0]),
            .ci (src_c[k]),
            .s  (blk_s[k]),
            .co (blk_co[k]),
            .p  (blk_p[k])
        );
    end

    // Carry into the MSB is recovered from the MSB sum bit: c = s ^ a ^ b.
    assign ovf_nxt = blk_s[NBLK-1][BLK-1] ^ src_a[NBLK-1][BLK-1]
                   ^ src_b[NBLK-1][BLK-1] ^ blk_co[NBLK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                sum_q[k]  <= '0;
                ar_q[k]   <= '0;
                br_q[k]   <= '0;
                mask_q[k] <= '0;
            end
        end else if (en) begin
            v_q   <= src_v;
            c_q   <= blk_co;
            ovf_q <= ovf_nxt;
            for (int k = 0; k < NBLK; k++) begin
                sum_q[k]  <= src_sum[k] | (word_t'(blk_s[k]) << (k * BLK));
                ar_q[k]   <= src_a[k] >> BLK;
                br_q[k]   <= src_b[k] >> BLK;
                mask_q[k] <= src_mask[k] | (mask_t'(blk_p[k]) << k);
            end
        end
    end

    assign out_valid = v_q[NBLK-1];
    assign s         = sum_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = ovf_q;
    assign skip_mask = mask_q[NBLK-1];

endmodule
